// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM state type and step-count helper for serial_sub
package serial_sub_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} serial_sub_state_t;

    function automatic int steps(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/serial_sub_if.sv
// serial_sub_if: operand/result handshake bundle for serial_sub (ovf present with SERIAL_SUB_OVF_EN)
interface serial_sub_if #(parameter int WIDTH = 8);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output in_valid, a, b, bin, out_ready,
                    input in_ready, out_valid, d, bout, ovf);
    modport slave (input in_valid, a, b, bin, out_ready,
                   output in_ready, out_valid, d, bout, ovf);
`else
    modport master (output in_valid, a, b, bin, out_ready,
                    input in_ready, out_valid, d, bout);
    modport slave (input in_valid, a, b, bin, out_ready,
                   output in_ready, out_valid, d, bout);
`endif

endinterface

// File: rtl/full_sub_cell.sv
// full_sub_cell: one-bit full subtractor, x - y - bi
module full_sub_cell (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub.sv
// serial_sub: digit-serial a - b - bin over WIDTH/DIGIT cycles; SERIAL_SUB_OVF_EN adds signed overflow
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic      clk,
    input logic      rst,
    serial_sub_if.slave io
);

    localparam int STEPS = steps(WIDTH, DIGIT);
    localparam int CW    = $clog2(STEPS + 1);

    if (WIDTH < 1 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_cfg
        $error("serial_sub: WIDTH must be a positive multiple of DIGIT");
    end

    serial_sub_state_t state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, d_q, d_d;
    logic              br_q, br_d, bout_q, bout_d, ov_q, ov_d;
    logic [DIGIT:0]    chain;
    logic [DIGIT-1:0]  diff;
    logic [WIDTH+DIGIT-1:0] shift_in;
    logic              last;
`ifdef SERIAL_SUB_OVF_EN
    logic              am_q, am_d, bm_q, bm_d, ovf_q, ovf_d;
`endif

    assign chain[0] = br_q;

    for (genvar g = 0; g < DIGIT; g++) begin : g_cell
        full_sub_cell u_cell (
            .x (a_q[g]),
            .y (b_q[g]),
            .bi(chain[g]),
            .d (diff[g]),
            .bo(chain[g+1])
        );
    end

    // New digit enters at the MSB end; works for DIGIT == WIDTH too
    assign shift_in = {diff, d_q};
    assign last     = cnt_q == CW'(STEPS - 1);

    // Next-state and datapath update for accept, shift and hand-off
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        br_d    = br_q;
        bout_d  = bout_q;
        ov_d    = ov_q;
`ifdef SERIAL_SUB_OVF_EN
        am_d    = am_q;
        bm_d    = bm_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: if (io.in_valid && io.in_ready) begin
                a_d     = io.a;
                b_d     = io.b;
                br_d    = io.bin;
                state_d = RUN;
`ifdef SERIAL_SUB_OVF_EN
                am_d    = io.a[WIDTH-1];
                bm_d    = io.b[WIDTH-1];
`endif
            end
            RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                d_d   = shift_in[WIDTH+DIGIT-1:DIGIT];
                br_d  = chain[DIGIT];
                cnt_d = last ? '0 : cnt_q + 1'b1;
                if (last) begin
                    bout_d  = chain[DIGIT];
                    ov_d    = 1'b1;
                    state_d = DONE;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (am_q ^ bm_q) & (am_q ^ diff[DIGIT-1]);
`endif
                end
            end
            DONE: if (io.out_ready) begin
                ov_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            ov_q    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            am_q    <= 1'b0;
            bm_q    <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            ov_q    <= ov_d;
`ifdef SERIAL_SUB_OVF_EN
            am_q    <= am_d;
            bm_q    <= bm_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign io.in_ready  = (state_q == IDLE) && !rst;
    assign io.out_valid = ov_q;
    assign io.d         = d_q;
    assign io.bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign io.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: scoreboard bench for serial_sub at DIGIT = 1, 4 and 8 (WIDTH = 8)
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sel;
    logic       in_valid, bin, out_ready;
    logic [7:0] a, b;
    logic       m_in_ready, m_out_valid, m_bout, m_ovf;
    logic [7:0] m_d;
    logic [9:0] sb[$];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    serial_sub_if #(.WIDTH(8)) i1 ();
    serial_sub_if #(.WIDTH(8)) i4 ();
    serial_sub_if #(.WIDTH(8)) i8 ();

    serial_sub #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .io(i1));
    serial_sub #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst(rst), .io(i4));
    serial_sub #(.WIDTH(8), .DIGIT(8)) dut8 (.clk(clk), .rst(rst), .io(i8));

    assign i1.in_valid  = in_valid && sel == 2'd0;
    assign i4.in_valid  = in_valid && sel == 2'd1;
    assign i8.in_valid  = in_valid && sel == 2'd2;
    assign i1.out_ready = out_ready && sel == 2'd0;
    assign i4.out_ready = out_ready && sel == 2'd1;
    assign i8.out_ready = out_ready && sel == 2'd2;
    assign i1.a = a;
    assign i4.a = a;
    assign i8.a = a;
    assign i1.b = b;
    assign i4.b = b;
    assign i8.b = b;
    assign i1.bin = bin;
    assign i4.bin = bin;
    assign i8.bin = bin;

    always_comb begin
        m_in_ready  = sel == 2'd0 ? i1.in_ready  : sel == 2'd1 ? i4.in_ready  : i8.in_ready;
        m_out_valid = sel == 2'd0 ? i1.out_valid : sel == 2'd1 ? i4.out_valid : i8.out_valid;
        m_d         = sel == 2'd0 ? i1.d         : sel == 2'd1 ? i4.d         : i8.d;
        m_bout      = sel == 2'd0 ? i1.bout      : sel == 2'd1 ? i4.bout      : i8.bout;
    end

`ifdef SERIAL_SUB_OVF_EN
    assign m_ovf = i1.ovf;
`else
    assign m_ovf = 1'b0;
`endif

    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic bi);
        logic [8:0] r;
        logic       ov;
        r  = {1'b0, x} - {1'b0, y} - {8'd0, bi};
        ov = (x[7] ^ y[7]) & (x[7] ^ r[7]);
        return {ov, r[8], r[7:0]};
    endfunction

    function automatic int steps_for(input logic [1:0] s);
        return s == 2'd0 ? 8 : s == 2'd1 ? 2 : 1;
    endfunction

    // Called at #1 after a rising edge; ends #1 after the accepting edge
    task automatic start_op(input logic [7:0] x, input logic [7:0] y, input logic bi);
        n_cmp++;
        if (m_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL start_in_ready sel=%0d got=%b want=1", sel, m_in_ready);
        end
        a = x;
        b = y;
        bin = bi;
        in_valid = 1'b1;
        sb.push_back(model(x, y, bi));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic finish_op(input string name, input int hold);
        int         lat;
        logic [9:0] exp;
        logic [7:0] d_seen;
        logic       bout_seen;
        lat = 0;
        while (!m_out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_cmp++;
        if (lat !== steps_for(sel)) begin
            n_err++;
            $display("FAIL %s_latency got=%0d want=%0d", name, lat, steps_for(sel));
        end
        exp = sb.size() > 0 ? sb.pop_front() : 10'h0;
        n_cmp++;
        if (m_d !== exp[7:0] || m_bout !== exp[8]) begin
            n_err++;
            $display("FAIL %s_result got d=%h bout=%b want d=%h bout=%b", name, m_d, m_bout, exp[7:0], exp[8]);
        end
`ifdef SERIAL_SUB_OVF_EN
        if (sel == 2'd0) begin
            n_cmp++;
            if (m_ovf !== exp[9]) begin
                n_err++;
                $display("FAIL %s_ovf got=%b want=%b", name, m_ovf, exp[9]);
            end
        end
`endif
        d_seen = m_d;
        bout_seen = m_bout;
        for (int k = 0; k < hold; k++) begin
            a = 8'hFF;
            b = 8'h00;
            in_valid = k[0];
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            n_cmp++;
            if (m_d !== d_seen || m_bout !== bout_seen || m_out_valid !== 1'b1 || m_in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL %s_hold%0d got d=%h bout=%b ov=%b ir=%b want d=%h bout=%b ov=1 ir=0",
                         name, k, m_d, m_bout, m_out_valid, m_in_ready, d_seen, bout_seen);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_cmp++;
        if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s_release got ov=%b ir=%b want ov=0 ir=1", name, m_out_valid, m_in_ready);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        sel = 2'd0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = 8'h0;
        b = 8'h0;
        bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (m_in_ready !== 1'b0 || m_out_valid !== 1'b0 || m_d !== 8'h00 || m_bout !== 1'b0) begin
            n_err++;
            $display("FAIL reset got ir=%b ov=%b d=%h bout=%b want 0 0 00 0", m_in_ready, m_out_valid, m_d, m_bout);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (m_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_in_ready got=%b want=1", m_in_ready);
        end
    endtask

    task automatic test_basic;
        sel = 2'd0;
        start_op(8'h05, 8'h03, 1'b0);
        finish_op("sub_05_03", 0);
        start_op(8'h03, 8'h05, 1'b0);
        finish_op("sub_03_05", 0);
        start_op(8'h00, 8'h00, 1'b1);
        finish_op("sub_00_00_b", 0);
        start_op(8'hFF, 8'hFF, 1'b1);
        finish_op("sub_ff_ff_b", 0);
        for (int i = 0; i < 4; i++) begin
            start_op(8'($urandom), 8'($urandom), 1'($urandom));
            finish_op("sub_rand", 0);
        end
    endtask

    task automatic test_backpressure;
        sel = 2'd0;
        start_op(8'h5A, 8'h3C, 1'b1);
        finish_op("backpressure", 5);
    endtask

    task automatic test_reset_mid_run;
        sel = 2'd0;
        start_op(8'h77, 8'h11, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (m_out_valid !== 1'b0 || m_d !== 8'h00 || m_in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset got ov=%b d=%h ir=%b want 0 00 0", m_out_valid, m_d, m_in_ready);
        end
        rst = 1'b0;
        sb.delete();
        #1;
        start_op(8'h10, 8'h20, 1'b0);
        finish_op("after_reset", 0);
    endtask

    task automatic test_digits;
        sel = 2'd1;
        #1;
        start_op(8'hA0, 8'h0F, 1'b0);
        finish_op("d4_a0_0f", 0);
        start_op(8'h12, 8'h34, 1'b1);
        finish_op("d4_12_34", 2);
        sel = 2'd2;
        #1;
        start_op(8'hA0, 8'h0F, 1'b0);
        finish_op("d8_a0_0f", 0);
        start_op(8'h00, 8'h01, 1'b0);
        finish_op("d8_00_01", 0);
        sel = 2'd0;
        #1;
    endtask

    task automatic test_ovf;
        sel = 2'd0;
        start_op(8'h80, 8'h01, 1'b0);
        finish_op("ovf_80_01", 0);
        start_op(8'h10, 8'h01, 1'b0);
        finish_op("ovf_10_01", 0);
        start_op(8'h7F, 8'hFF, 1'b0);
        finish_op("ovf_7f_ff", 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid_run();
        test_digits();
        test_ovf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
